// File: rtl/vending_pkg.sv
// Shared encodings for the multi-item vending controller.
// State codes and coin codes used by the controller and its bench.
package vending_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] VEND    = 2'd2;
  localparam logic [1:0] CHANGE  = 2'd3;

  localparam logic [1:0] COIN_A    = 2'b00;
  localparam logic [1:0] COIN_B    = 2'b01;
  localparam logic [1:0] COIN_C    = 2'b10;
  localparam logic [1:0] COIN_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_COLLECT = COLLECT,
    ST_VEND    = VEND,
    ST_CHANGE  = CHANGE
  } state_e;

endpackage

// File: rtl/vending_price_lut.sv
// Item select to price lookup, with a flag for selects
// that do not name a stocked product.
module vending_price_lut
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int SEL_W     = 2,
  parameter int CREDIT_W  = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES =
    {8'd50, 8'd35, 8'd25, 8'd15}
) (
  input  logic [SEL_W-1:0]    sel,
  output logic [CREDIT_W-1:0] price,
  output logic                in_range
);

  always_comb begin
    price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel == SEL_W'(i)) begin
        price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  assign in_range = 32'(sel) < NUM_ITEMS;

endmodule

// File: rtl/vending_ctrl.sv
// Multi-item vending controller: binary credit register,
// per-item prices, refund and unit-coin change handshake.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS   = 4,
  parameter int SEL_W       = 2,
  parameter int CREDIT_W    = 8,
  parameter int COIN0_VAL   = 5,
  parameter int COIN1_VAL   = 10,
  parameter int COIN2_VAL   = 25,
  parameter int MAX_CREDIT  = 95,
  parameter int CHANGE_UNIT = 5,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES =
    {8'd50, 8'd35, 8'd25, 8'd15}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  output logic                coin_reject,
  input  logic                buy,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_item,
  output logic                buy_err,
  output logic                change_valid,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  if ((1 << SEL_W) < NUM_ITEMS) begin : g_sel_chk
    $error("SEL_W too narrow for NUM_ITEMS");
  end
  if (COIN0_VAL % CHANGE_UNIT != 0 ||
      COIN1_VAL % CHANGE_UNIT != 0 ||
      COIN2_VAL % CHANGE_UNIT != 0 ||
      MAX_CREDIT % CHANGE_UNIT != 0) begin : g_coin_chk
    $error("coin values must be multiples of CHANGE_UNIT");
  end
  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price_chk
    if (PRICES[i*CREDIT_W +: CREDIT_W] % CHANGE_UNIT != 0)
    begin : g_err
      $error("price must be a multiple of CHANGE_UNIT");
    end
  end

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    item_q, item_d;
  logic                rej_q, rej_d;
  logic                vv_q, vv_d;
  logic                berr_q, berr_d;
  logic                cv_q, cv_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] price;
  logic                sel_ok;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic                coin_ok;

  vending_price_lut #(
    .NUM_ITEMS (NUM_ITEMS),
    .SEL_W     (SEL_W),
    .CREDIT_W  (CREDIT_W),
    .PRICES    (PRICES)
  ) u_lut (
    .sel      (sel),
    .price    (price),
    .in_range (sel_ok)
  );

  always_comb begin
    unique case (coin)
      COIN_A:  coin_val = CREDIT_W'(COIN0_VAL);
      COIN_B:  coin_val = CREDIT_W'(COIN1_VAL);
      COIN_C:  coin_val = CREDIT_W'(COIN2_VAL);
      default: coin_val = '0;
    endcase
  end

  // One extra bit so an over-limit sum is seen, not wrapped.
  assign sum = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_ok = (coin != COIN_RSVD) &&
                   (sum <= (CREDIT_W+1)'(MAX_CREDIT));

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    rej_d    = 1'b0;
    vv_d     = 1'b0;
    berr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (cancel) begin
          rej_d = coin_valid;
          if (credit_q != '0) state_d = ST_CHANGE;
        end else if (buy) begin
          rej_d = coin_valid;
          if (sel_ok && credit_q >= price) begin
            credit_d = credit_q - price;
            item_d   = sel;
            vv_d     = 1'b1;
            state_d  = ST_VEND;
          end else begin
            berr_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = ST_COLLECT;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ST_VEND: begin
        rej_d   = coin_valid;
        berr_d  = buy;
        state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        rej_d  = coin_valid;
        berr_d = buy;
        if (cv_q && change_ready) begin
          credit_d = credit_q - CREDIT_W'(CHANGE_UNIT);
          if (credit_d == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cv_d   = (state_d == ST_CHANGE);
    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      item_q   <= '0;
      rej_q    <= 1'b0;
      vv_q     <= 1'b0;
      berr_q   <= 1'b0;
      cv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      rej_q    <= rej_d;
      vv_q     <= vv_d;
      berr_q   <= berr_d;
      cv_q     <= cv_d;
      busy_q   <= busy_d;
    end
  end

  assign coin_reject  = rej_q;
  assign vend_valid   = vv_q;
  assign vend_item    = item_q;
  assign buy_err      = berr_q;
  assign change_valid = cv_q;
  assign credit       = credit_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Bench for vending_ctrl: directed scenarios plus random
// traffic against a transaction-level credit model.
module tb_vending_ctrl;
  import vending_pkg::*;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          coin_valid = 1'b0;
  logic [1:0]    coin = 2'b00;
  logic          buy = 1'b0;
  logic [SW-1:0] sel = '0;
  logic          cancel = 1'b0;
  logic          change_ready = 1'b0;
  logic          coin_reject, vend_valid, buy_err;
  logic          change_valid, busy;
  logic [SW-1:0] vend_item;
  logic [CW-1:0] credit;

  logic          d2_coin_valid = 1'b0;
  logic [1:0]    d2_coin = 2'b00;
  logic          d2_buy = 1'b0;
  logic [SW-1:0] d2_sel = '0;
  logic          d2_cancel = 1'b0;
  logic          d2_change_ready = 1'b0;
  logic          d2_coin_reject, d2_vend_valid, d2_buy_err;
  logic          d2_change_valid, d2_busy;
  logic [SW-1:0] d2_vend_item;
  logic [CW-1:0] d2_credit;

  always #5 clk = ~clk;

  vending_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin(coin),
    .coin_reject(coin_reject),
    .buy(buy), .sel(sel), .cancel(cancel),
    .vend_valid(vend_valid), .vend_item(vend_item),
    .buy_err(buy_err),
    .change_valid(change_valid),
    .change_ready(change_ready),
    .credit(credit), .busy(busy)
  );

  vending_ctrl #(
    .NUM_ITEMS(3),
    .PRICES({8'd35, 8'd25, 8'd15})
  ) dut3 (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(d2_coin_valid), .coin(d2_coin),
    .coin_reject(d2_coin_reject),
    .buy(d2_buy), .sel(d2_sel), .cancel(d2_cancel),
    .vend_valid(d2_vend_valid), .vend_item(d2_vend_item),
    .buy_err(d2_buy_err),
    .change_valid(d2_change_valid),
    .change_ready(d2_change_ready),
    .credit(d2_credit), .busy(d2_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: credit in cents plus a coarse activity phase.
  localparam int PH_OPEN = 0;
  localparam int PH_DISP = 1;
  localparam int PH_PAY  = 2;
  int price_tab [N] = '{15, 25, 35, 50};
  int m_credit = 0, m_item = 0, m_phase = PH_OPEN;
  bit e_rej, e_vv, e_berr;

  function automatic int coin_value(input logic [1:0] c);
    case (c)
      2'b00:   return 5;
      2'b01:   return 10;
      2'b10:   return 25;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    int v;
    e_rej = 0; e_vv = 0; e_berr = 0;
    if (m_phase != PH_OPEN) begin
      e_rej  = coin_valid;
      e_berr = buy;
      if (m_phase == PH_DISP) begin
        m_phase = (m_credit > 0) ? PH_PAY : PH_OPEN;
      end else if (change_ready) begin
        m_credit -= 5;
        if (m_credit == 0) m_phase = PH_OPEN;
      end
    end else if (cancel) begin
      e_rej = coin_valid;
      if (m_credit > 0) m_phase = PH_PAY;
    end else if (buy) begin
      e_rej = coin_valid;
      if (int'(sel) >= N || m_credit < price_tab[sel]) begin
        e_berr = 1;
      end else begin
        m_credit -= price_tab[sel];
        m_item = int'(sel);
        e_vv = 1;
        m_phase = PH_DISP;
      end
    end else if (coin_valid) begin
      v = coin_value(coin);
      if (v < 0 || m_credit + v > 95) e_rej = 1;
      else m_credit += v;
    end
  endtask

  task automatic compare_all();
    check("credit", 32'(credit), m_credit);
    check("credit_mod", 32'(credit) % 5, 0);
    check("coin_reject", 32'(coin_reject), 32'(e_rej));
    check("vend_valid", 32'(vend_valid), 32'(e_vv));
    check("vend_item", 32'(vend_item), m_item);
    check("buy_err", 32'(buy_err), 32'(e_berr));
    check("change_valid", 32'(change_valid),
          32'(m_phase == PH_PAY));
    check("busy", 32'(busy), 32'(m_phase != PH_OPEN));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit cv, input logic [1:0] c,
                       input bit b, input logic [SW-1:0] s,
                       input bit cn, input bit cr);
    coin_valid = cv; coin = c; buy = b; sel = s;
    cancel = cn; change_ready = cr;
  endtask

  task automatic idle(input bit cr);
    drive(0, 2'b00, 0, '0, 0, cr);
  endtask

  task automatic insert(input logic [1:0] c);
    drive(1, c, 0, '0, 0, 0);
    tick();
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_credit", 32'(credit), 0);
    check("rst_cv", 32'(change_valid), 0);
    check("rst_vv", 32'(vend_valid), 0);
    check("rst_item", 32'(vend_item), 0);
    check("rst_rej", 32'(coin_reject), 0);
    check("rst_berr", 32'(buy_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_d2_credit", 32'(d2_credit), 0);
    m_credit = 0; m_item = 0; m_phase = PH_OPEN;
    e_rej = 0; e_vv = 0; e_berr = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(output int beats);
    beats = 0;
    idle(1);
    for (int i = 0; i < 40 && change_valid; i++) begin
      tick();
      beats++;
    end
    check("drain_done", 32'(change_valid), 0);
  endtask

  task automatic refund();
    int b;
    drive(0, 2'b00, 0, '0, 1, 0);
    tick();
    drain(b);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    logic [1:0] seq [5];
    apply_reset();

    // Three-item variant: sel 3 is out of range.
    idle(0);
    d2_coin_valid = 1; d2_coin = 2'b10;
    tick();
    check("d3_credit", 32'(d2_credit), 25);
    d2_coin_valid = 0; d2_buy = 1; d2_sel = 2'd3;
    tick();
    check("d3_sel3_err", 32'(d2_buy_err), 1);
    check("d3_sel3_credit", 32'(d2_credit), 25);
    d2_sel = 2'd2;
    tick();
    check("d3_sel2_err", 32'(d2_buy_err), 1);
    d2_sel = 2'd1;
    tick();
    check("d3_vend", 32'(d2_vend_valid), 1);
    check("d3_item", 32'(d2_vend_item), 1);
    check("d3_credit0", 32'(d2_credit), 0);
    d2_buy = 0;
    tick();
    check("d3_idle_busy", 32'(d2_busy), 0);
    check("d3_idle_cv", 32'(d2_change_valid), 0);

    // 10+10, buy item 0, one change beat.
    insert(2'b01);
    insert(2'b01);
    check("s1_credit20", 32'(credit), 20);
    drive(0, 2'b00, 1, 2'd0, 0, 0);
    tick();
    check("s1_vend", 32'(vend_valid), 1);
    check("s1_item", 32'(vend_item), 0);
    check("s1_credit5", 32'(credit), 5);
    idle(0);
    tick();
    check("s1_cv", 32'(change_valid), 1);
    drain(beats);
    check("s1_beats", beats, 1);
    check("s1_credit0", 32'(credit), 0);

    // Over-limit coin at 90, then top up to 95.
    seq = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    foreach (seq[i]) insert(seq[i]);
    check("s2_credit90", 32'(credit), 90);
    insert(2'b10);
    check("s2_reject", 32'(coin_reject), 1);
    check("s2_hold90", 32'(credit), 90);
    insert(2'b00);
    check("s2_credit95", 32'(credit), 95);
    refund();

    // Insufficient credit keeps COLLECT.
    insert(2'b01);
    insert(2'b01);
    drive(0, 2'b00, 1, 2'd1, 0, 0);
    tick();
    check("s3_berr", 32'(buy_err), 1);
    check("s3_credit", 32'(credit), 20);
    check("s3_state", 32'(dut.state_q), 32'(COLLECT));
    refund();

    // Refund of 30 with hopper stalled.
    insert(2'b10);
    insert(2'b00);
    drive(0, 2'b00, 0, '0, 1, 0);
    tick();
    idle(0);
    repeat (4) begin
      tick();
      check("s4_stall_cv", 32'(change_valid), 1);
      check("s4_stall_credit", 32'(credit), 30);
    end
    drain(beats);
    check("s4_beats", beats, 6);

    // Buy and coin together: coin bounces.
    insert(2'b01);
    insert(2'b00);
    drive(1, 2'b10, 1, 2'd0, 0, 0);
    tick();
    check("s5_vend", 32'(vend_valid), 1);
    check("s5_reject", 32'(coin_reject), 1);
    check("s5_credit", 32'(credit), 0);
    idle(0);
    tick();
    check("s5_idle", 32'(busy), 0);

    // Reset in the middle of a refund.
    insert(2'b01);
    insert(2'b01);
    drive(0, 2'b00, 0, '0, 1, 0);
    tick();
    idle(0);
    tick();
    check("s6_cv", 32'(change_valid), 1);
    apply_reset();
    idle(1);
    repeat (3) begin
      tick();
      check("s6_no_cv", 32'(change_valid), 0);
    end
    insert(2'b00);
    refund();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 40,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 12,
            SW'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 60);
      tick();
      if ($urandom_range(0, 299) == 0) apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
